// File: rtl/ppl_frame_sched_if.sv
// Signal bundle between the frame scheduler, its frame/pose source and the march pipeline.
interface ppl_frame_sched_if;
  logic               frame_start;
  logic        [17:0] p_pos_x;
  logic        [17:0] p_pos_y;
  logic        [17:0] p_pos_z;
  logic signed [19:0] p_angle_x;
  logic signed [19:0] p_angle_y;
  logic               ret_valid;
  logic               ret_done;

  logic        [17:0] lat_pos_x;
  logic        [17:0] lat_pos_y;
  logic        [17:0] lat_pos_z;
  logic signed [19:0] lat_angle_x;
  logic signed [19:0] lat_angle_y;
  logic               next_en;
  logic               scanner_stop;
  logic               busy;
  logic               frame_done;
  logic               frame_overrun;
  logic        [19:0] pix_issued;

  modport master (
    output frame_start, p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y,
    output ret_valid, ret_done,
    input  lat_pos_x, lat_pos_y, lat_pos_z, lat_angle_x, lat_angle_y,
    input  next_en, scanner_stop, busy, frame_done, frame_overrun, pix_issued
  );

  modport slave (
    input  frame_start, p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y,
    input  ret_valid, ret_done,
    output lat_pos_x, lat_pos_y, lat_pos_z, lat_angle_x, lat_angle_y,
    output next_en, scanner_stop, busy, frame_done, frame_overrun, pix_issued
  );
endinterface

// File: rtl/ppl_frame_sched.sv
// Entry-slot scheduler for the ray-march ring: inject / recirculate / bubble each cycle,
// per-frame pose latch, in-flight tracking and frame completion reporting.
module ppl_frame_sched #(
  parameter int H_DISP    = 1280,
  parameter int V_DISP    = 720,
  parameter int PPL_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  ppl_frame_sched_if.slave bus
);

  localparam int                PIX_TOTAL_I = H_DISP * V_DISP;
  localparam logic [19:0]       PIX_LAST    = 20'(PIX_TOTAL_I - 1);
  localparam int                INF_W       = $clog2(PPL_DEPTH + 1);
  localparam logic [INF_W-1:0]  INF_MAX     = INF_W'(PPL_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [19:0]        pix_issued_reg;
  logic [19:0]        pix_issued_next;
  logic [INF_W-1:0]   inflight_reg;
  logic [INF_W-1:0]   inflight_next;
  logic               busy_reg;
  logic               frame_done_reg;
  logic               frame_overrun_reg;

  logic               recirc;
  logic               retire;
  logic               inject;
  logic               scanner_stop_c;
  logic               latch_pose;

  logic        [17:0] pos_live     [3];
  logic        [17:0] pos_lat_reg  [3];
  logic signed [19:0] ang_live     [2];
  logic signed [19:0] ang_lat_reg  [2];

  assign recirc = bus.ret_valid & ~bus.ret_done;
  assign retire = bus.ret_valid & bus.ret_done;
  assign inject = ~recirc & ~scanner_stop_c;

  // Reset forces the entry mux to the scanner side even if the tail still shows a ray.
  assign bus.next_en      = rst | ~recirc;
  assign bus.scanner_stop = scanner_stop_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pix_issued_next = pix_issued_reg;
    scanner_stop_c  = 1'b1;
    latch_pose      = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.frame_start) begin
          state_next      = ST_RUN;
          pix_issued_next = '0;
          latch_pose      = 1'b1;
        end
      end
      ST_RUN: begin
        scanner_stop_c = 1'b0;
        // A recirculating tail ray owns the entry slot; the scanner waits.
        if (!recirc) begin
          pix_issued_next = pix_issued_reg + 20'd1;
          if (pix_issued_reg == PIX_LAST) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (inflight_reg == '0) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    inflight_next = inflight_reg;
    if (inject && !retire) begin
      inflight_next = inflight_reg + INF_W'(1);
    end else if (!inject && retire && (inflight_reg != '0)) begin
      inflight_next = inflight_reg - INF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_issued_reg    <= '0;
      inflight_reg      <= '0;
      busy_reg          <= 1'b0;
      frame_done_reg    <= 1'b0;
      frame_overrun_reg <= 1'b0;
    end else begin
      pix_issued_reg    <= pix_issued_next;
      inflight_reg      <= inflight_next;
      busy_reg          <= (state_next != ST_IDLE);
      frame_done_reg    <= (state_next == ST_DONE);
      frame_overrun_reg <= bus.frame_start & (state_reg != ST_IDLE);
    end
  end

  assign pos_live[0] = bus.p_pos_x;
  assign pos_live[1] = bus.p_pos_y;
  assign pos_live[2] = bus.p_pos_z;
  assign ang_live[0] = bus.p_angle_x;
  assign ang_live[1] = bus.p_angle_y;

  // The pose is captured only when a frame is accepted, so every pixel sees one pose.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pos_lat
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pos_lat_reg[gi] <= '0;
        end else if (latch_pose) begin
          pos_lat_reg[gi] <= pos_live[gi];
        end
      end
    end
    for (gi = 0; gi < 2; gi++) begin : g_ang_lat
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ang_lat_reg[gi] <= '0;
        end else if (latch_pose) begin
          ang_lat_reg[gi] <= ang_live[gi];
        end
      end
    end
  endgenerate

  assign bus.lat_pos_x     = pos_lat_reg[0];
  assign bus.lat_pos_y     = pos_lat_reg[1];
  assign bus.lat_pos_z     = pos_lat_reg[2];
  assign bus.lat_angle_x   = ang_lat_reg[0];
  assign bus.lat_angle_y   = ang_lat_reg[1];
  assign bus.busy          = busy_reg;
  assign bus.frame_done    = frame_done_reg;
  assign bus.frame_overrun = frame_overrun_reg;
  assign bus.pix_issued    = pix_issued_reg;

  a_no_retire_underflow: assert property (@(posedge clk) disable iff (rst)
    !(retire && (inflight_reg == '0)));
  a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
    inflight_reg <= INF_MAX);

endmodule
